// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register window map, mode encoding, id width.
package irq_pkg;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned IRQ_ID_W = 5;

    localparam logic [ADDR_W-1:0] IRQ_PENDING = 3'd0;
    localparam logic [ADDR_W-1:0] IRQ_ENABLE  = 3'd1;
    localparam logic [ADDR_W-1:0] IRQ_MODE    = 3'd2;
    localparam logic [ADDR_W-1:0] IRQ_FORCE   = 3'd3;
    localparam logic [ADDR_W-1:0] IRQ_CLAIM   = 3'd4;

    localparam logic MODE_EDGE  = 1'b1;
    localparam logic MODE_LEVEL = 1'b0;

    typedef struct packed {
        logic              wen;
        logic              ren;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  wdata;
    } reg_req_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser with a delayed copy for rising-edge detection.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic level,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain   <= '0;
            level_d <= 1'b0;
        end else begin
            chain[0] <= src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            level_d <= chain[SYNC_STAGES-1];
        end
    end

    assign level  = chain[SYNC_STAGES-1];
    assign rise_c = level & ~level_d;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-source sync/edge detect, pending latches, mask, fixed
// priority (low index wins), claim handshake and a small register window.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned       NUM_SRC      = 16,
    parameter int unsigned       SYNC_STAGES  = 2,
    parameter logic [NUM_SRC-1:0] ENABLE_RESET = '0,
    parameter logic [NUM_SRC-1:0] MODE_RESET   = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_SRC-1:0]  src_in,
    input  logic                reg_wen,
    input  logic                reg_ren,
    input  logic [ADDR_W-1:0]   reg_addr,
    input  logic [REG_W-1:0]    reg_wdata,
    output logic [REG_W-1:0]    reg_rdata,
    output logic                irq_out,
    output logic [IRQ_ID_W-1:0] irq_id
);

    reg_req_t             req_c;
    logic [NUM_SRC-1:0]   level;
    logic [NUM_SRC-1:0]   rise_c;
    logic [NUM_SRC-1:0]   pending_q;
    logic [NUM_SRC-1:0]   enable_q;
    logic [NUM_SRC-1:0]   mode_q;
    logic [NUM_SRC-1:0]   w1c_c;
    logic [NUM_SRC-1:0]   force_c;
    logic [NUM_SRC-1:0]   claim_clr_c;
    logic [NUM_SRC-1:0]   active_c;
    logic [NUM_SRC-1:0]   pending_n_c;
    logic [IRQ_ID_W-1:0]  id_c;
    logic                 any_c;
    logic                 claim_c;
    logic [REG_W-1:0]     rdata_c;
    logic                 unused_wdata;

    assign req_c = '{wen: reg_wen, ren: reg_ren, addr: reg_addr, wdata: reg_wdata};
    // Only the low NUM_SRC bits of a write carry meaning.
    assign unused_wdata = ^req_c.wdata;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .src    (src_in[g]),
            .level  (level[g]),
            .rise_c (rise_c[g])
        );
    end

    // Write strobes that act on pending this cycle.
    always_comb begin
        w1c_c   = '0;
        force_c = '0;
        if (req_c.wen && req_c.addr == IRQ_PENDING) w1c_c   = req_c.wdata[NUM_SRC-1:0];
        if (req_c.wen && req_c.addr == IRQ_FORCE)   force_c = req_c.wdata[NUM_SRC-1:0];
    end

    // Priority encoder, lowest active index wins.
    always_comb begin
        active_c = pending_q & enable_q;
        any_c    = |active_c;
        id_c     = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active_c[i]) id_c = IRQ_ID_W'(i);
        end
    end

    // Claim clears the winning source only when it is edge-triggered; set beats clear.
    always_comb begin
        claim_c     = req_c.ren && (req_c.addr == IRQ_CLAIM) && any_c;
        claim_clr_c = '0;
        pending_n_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr_c[i] = claim_c && (id_c == IRQ_ID_W'(i)) && (mode_q[i] == MODE_EDGE);
            if (mode_q[i] == MODE_LEVEL) begin
                pending_n_c[i] = level[i] | force_c[i];
            end else begin
                pending_n_c[i] = rise_c[i] | force_c[i]
                               | (pending_q[i] & ~(w1c_c[i] | claim_clr_c[i]));
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        if (req_c.ren) begin
            case (req_c.addr)
                IRQ_PENDING: rdata_c = REG_W'(pending_q);
                IRQ_ENABLE:  rdata_c = REG_W'(enable_q);
                IRQ_MODE:    rdata_c = REG_W'(mode_q);
                IRQ_CLAIM:   rdata_c = {any_c, {(REG_W - 1 - IRQ_ID_W){1'b0}}, id_c};
                default:     rdata_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            enable_q  <= ENABLE_RESET;
            mode_q    <= MODE_RESET;
            irq_out   <= 1'b0;
            irq_id    <= '0;
            reg_rdata <= '0;
        end else begin
            pending_q <= pending_n_c;
            if (req_c.wen && req_c.addr == IRQ_ENABLE) enable_q <= req_c.wdata[NUM_SRC-1:0];
            if (req_c.wen && req_c.addr == IRQ_MODE)   mode_q   <= req_c.wdata[NUM_SRC-1:0];
            irq_out   <= any_c;
            if (any_c) irq_id <= id_c;
            reg_rdata <= rdata_c;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register-access vector table plus latency/corner sequences.
module tb_irq_controller;
    import irq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] src_in;
    logic        reg_wen;
    logic        reg_ren;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        irq_out;
    logic [4:0]  irq_id;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    irq_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_in    (src_in),
        .reg_wen   (reg_wen),
        .reg_ren   (reg_ren),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq_out   (irq_out),
        .irq_id    (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_wen   = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_wen   = 1'b0;
        reg_wdata = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        reg_ren  = 1'b1;
        reg_addr = a;
        tick();
        reg_ren  = 1'b0;
        d        = reg_rdata;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        src_in    = '0;
        reg_wen   = 1'b0;
        reg_ren   = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;

        vecs[0]  = '{1'b1, 1'b0, IRQ_ENABLE,  32'h1234_ABCD, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, IRQ_ENABLE,  32'h0,         32'h0000_ABCD};
        vecs[2]  = '{1'b1, 1'b0, IRQ_MODE,    32'h0000_00FF, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, IRQ_MODE,    32'h0,         32'h0000_00FF};
        vecs[4]  = '{1'b0, 1'b1, IRQ_FORCE,   32'h0,         32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'd5,        32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 3'd5,        32'h0,         32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'd6,        32'h0,         32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'd7,        32'h0,         32'h0};
        vecs[9]  = '{1'b1, 1'b0, IRQ_FORCE,   32'h0000_0001, 32'h0};
        vecs[10] = '{1'b0, 1'b1, IRQ_PENDING, 32'h0,         32'h0000_0001};
        vecs[11] = '{1'b0, 1'b1, IRQ_CLAIM,   32'h0,         32'h8000_0000};
        vecs[12] = '{1'b0, 1'b1, IRQ_PENDING, 32'h0,         32'h0};
        vecs[13] = '{1'b1, 1'b0, IRQ_FORCE,   32'h0000_0002, 32'h0};
        vecs[14] = '{1'b1, 1'b0, IRQ_PENDING, 32'h0000_0002, 32'h0};
        vecs[15] = '{1'b0, 1'b1, IRQ_PENDING, 32'h0,         32'h0};
        vecs[16] = '{1'b1, 1'b0, IRQ_FORCE,   32'hFFFF_0000, 32'h0};
        vecs[17] = '{1'b0, 1'b1, IRQ_PENDING, 32'h0,         32'h0};
        vecs[18] = '{1'b1, 1'b1, IRQ_ENABLE,  32'h0000_0005, 32'h0000_ABCD};
        vecs[19] = '{1'b0, 1'b1, IRQ_ENABLE,  32'h0,         32'h0000_0005};
        vecs[20] = '{1'b0, 1'b1, IRQ_CLAIM,   32'h0,         32'h0};
        vecs[21] = '{1'b1, 1'b0, IRQ_FORCE,   32'h0000_0100, 32'h0};
        vecs[22] = '{1'b0, 1'b1, IRQ_PENDING, 32'h0,         32'h0000_0100};
        vecs[23] = '{1'b0, 1'b1, IRQ_PENDING, 32'h0,         32'h0};

        repeat (3) tick();
        check("reset_irq_out", 32'(irq_out), 32'h0);
        check("reset_rdata", reg_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        rd_chk("reset_enable", IRQ_ENABLE, 32'h0);
        rd_chk("reset_mode", IRQ_MODE, 32'h0000_FFFF);

        // Register-access table
        for (int k = 0; k < NVEC; k++) begin
            reg_wen   = vecs[k].wen;
            reg_ren   = vecs[k].ren;
            reg_addr  = vecs[k].addr;
            reg_wdata = vecs[k].wdata;
            tick();
            reg_wen   = 1'b0;
            reg_ren   = 1'b0;
            reg_wdata = '0;
            if (vecs[k].ren) check($sformatf("vec%0d", k), reg_rdata, vecs[k].rdata);
        end

        // 1: asynchronous reset mid-stream
        wr(IRQ_ENABLE, 32'h0000_FFFF);
        src_in = 16'hFFFF;
        repeat (6) tick();
        check("t1_pre_irq_out", 32'(irq_out), 32'h1);
        rd_chk("t1_pre_pending", IRQ_PENDING, 32'h0000_FFFF);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_irq_out", 32'(irq_out), 32'h0);
        check("t1_async_rdata", reg_rdata, 32'h0);
        #2 rst_n = 1'b1;
        rd_chk("t1_pending_after", IRQ_PENDING, 32'h0);
        check("t1_irq_out_after", 32'(irq_out), 32'h0);
        src_in = '0;
        repeat (5) tick();
        wr(IRQ_PENDING, 32'h0000_FFFF);
        rd_chk("t1_cleared", IRQ_PENDING, 32'h0);

        // 2: one-cycle pulse latency
        wr(IRQ_ENABLE, 32'h0000_0004);
        src_in = 16'h0004;
        tick();
        src_in = '0;
        tick();
        check("t2_e2_irq_out", 32'(irq_out), 32'h0);
        rd_chk("t2_e3_pending_pre", IRQ_PENDING, 32'h0);
        check("t2_e3_irq_out", 32'(irq_out), 32'h0);
        rd_chk("t2_e4_pending", IRQ_PENDING, 32'h0000_0004);
        check("t2_e4_irq_out", 32'(irq_out), 32'h1);
        check("t2_e4_irq_id", 32'(irq_id), 32'd2);
        wr(IRQ_PENDING, 32'h0000_0004);
        tick();
        check("t2_drop_irq_out", 32'(irq_out), 32'h0);
        check("t2_hold_irq_id", 32'(irq_id), 32'd2);

        // 3: priority and claim
        wr(IRQ_ENABLE, 32'h0000_FFFF);
        src_in = 16'h0022;
        repeat (4) tick();
        check("t3_irq_out", 32'(irq_out), 32'h1);
        check("t3_irq_id_1", 32'(irq_id), 32'd1);
        rd_chk("t3_claim", IRQ_CLAIM, 32'h8000_0001);
        rd_chk("t3_pending", IRQ_PENDING, 32'h0000_0020);
        check("t3_irq_id_5", 32'(irq_id), 32'd5);
        src_in = '0;
        wr(IRQ_PENDING, 32'h0000_0020);
        rd_chk("t3_cleared", IRQ_PENDING, 32'h0);

        // 4: level mode ignores W1C and claim
        wr(IRQ_MODE, 32'h0000_FFF7);
        src_in = 16'h0008;
        repeat (4) tick();
        rd_chk("t4_pending", IRQ_PENDING, 32'h0000_0008);
        wr(IRQ_PENDING, 32'h0000_0008);
        rd_chk("t4_after_w1c", IRQ_PENDING, 32'h0000_0008);
        rd_chk("t4_claim", IRQ_CLAIM, 32'h8000_0003);
        rd_chk("t4_after_claim", IRQ_PENDING, 32'h0000_0008);
        src_in = '0;
        tick();
        tick();
        rd_chk("t4_drop_e3_pre", IRQ_PENDING, 32'h0000_0008);
        rd_chk("t4_drop_e4", IRQ_PENDING, 32'h0);
        wr(IRQ_MODE, 32'h0000_FFFF);

        // 5: set beats W1C in the same cycle
        src_in = 16'h0004;
        tick();
        tick();
        wr(IRQ_PENDING, 32'h0000_0004);
        rd_chk("t5_set_wins", IRQ_PENDING, 32'h0000_0004);
        src_in = '0;
        repeat (3) tick();
        wr(IRQ_PENDING, 32'h0000_0004);
        rd_chk("t5_cleared", IRQ_PENDING, 32'h0);

        // 6: forced interrupt on a masked source
        wr(IRQ_ENABLE, 32'h0);
        wr(IRQ_FORCE, 32'h0000_0080);
        rd_chk("t6_pending", IRQ_PENDING, 32'h0000_0080);
        check("t6_masked_irq_out", 32'(irq_out), 32'h0);
        wr(IRQ_ENABLE, 32'h0000_0080);
        check("t6_w_irq_out", 32'(irq_out), 32'h0);
        tick();
        check("t6_irq_out", 32'(irq_out), 32'h1);
        check("t6_irq_id", 32'(irq_id), 32'd7);
        wr(IRQ_ENABLE, 32'h0);
        tick();
        check("t6_off_irq_out", 32'(irq_out), 32'h0);
        check("t6_off_irq_id", 32'(irq_id), 32'd7);
        rd_chk("t6_claim_none", IRQ_CLAIM, 32'h0);
        rd_chk("t6_pending_kept", IRQ_PENDING, 32'h0000_0080);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
